// File: rtl/macc_pkg.sv
// Shared types and constants for the MACC sequencing controller.
package macc_pkg;

    localparam int DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN,
        DONE
    } state_e;

    localparam logic [2:0] EN_A = 3'b100;
    localparam logic [2:0] EN_B = 3'b010;
    localparam logic [2:0] EN_C = 3'b001;

endpackage

// File: rtl/macc_obuf.sv
// Two-entry FIFO holding C words read back from the MACC.
module macc_obuf
    import macc_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rp_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wp_d  = do_push ? ~wp_q : wp_q;
        rp_d  = do_pop ? ~rp_q : rp_q;
        cnt_d = cnt_q + {1'b0, do_push}
                      - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) mem_q[wp_q] <= data_i;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/macc_ctrl.sv
// Sequencer: loads A/B into the MACC, waits, drains C to the host.
// Define MACC_CTRL_PERF_EN to build the job cycle counter.
module macc_ctrl
    import macc_pkg::*;
#(
    parameter int N_ELEM         = 16,
    parameter int COMPUTE_CYCLES = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] mat_wdata,
    output logic [2:0]    wen,
    output logic [2:0]    ren,
    input  logic [DW-1:0] c_rdata,
    output logic [31:0]   perf_cycles
);

    localparam int BW = $clog2(N_ELEM + 1);
    localparam int CW = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [BW-1:0] LAST  = BW'(N_ELEM - 1);
    localparam logic [BW-1:0] NW    = BW'(N_ELEM);
    localparam logic [CW-1:0] CLAST = CW'(COMPUTE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] rd_q, rd_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          infl_q, infl_d;
    logic          pop;
    logic          ob_empty;
    logic [1:0]    ob_cnt;
    logic [2:0]    pending;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_valid = ~ob_empty;
    assign pop       = out_valid & out_ready;
    // Buffered words plus the read still in flight must fit in 2 slots.
    assign pending   = {1'b0, ob_cnt} + {2'b00, infl_q};

    macc_obuf u_obuf (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (infl_q),
        .data_i  (c_rdata),
        .pop_i   (pop),
        .data_o  (out_data),
        .full_o  (),
        .empty_o (ob_empty),
        .count_o (ob_cnt)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        cyc_d     = cyc_q;
        infl_d    = 1'b0;
        in_ready  = 1'b0;
        wen       = 3'b000;
        ren       = 3'b000;
        mat_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    beat_d  = '0;
                    rd_d    = '0;
                    acc_d   = '0;
                    cyc_d   = '0;
                end
            end
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen       = (state_q == LOAD_A) ? EN_A : EN_B;
                    mat_wdata = in_data;
                    if (beat_q == LAST) begin
                        beat_d  = '0;
                        cyc_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : COMPUTE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cyc_q == CLAST) state_d = DRAIN;
                else cyc_d = cyc_q + 1'b1;
            end
            DRAIN: begin
                if (pending < 3'd2 && rd_q != NW) begin
                    ren    = EN_C;
                    rd_d   = rd_q + 1'b1;
                    infl_d = 1'b1;
                end
                if (pop) begin
                    if (acc_q == LAST) state_d = DONE;
                    else acc_d = acc_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rd_q    <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            cyc_q   <= cyc_d;
            infl_q  <= infl_d;
        end
    end

`ifdef MACC_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start) perf_d = '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) perf_q <= '0;
        else perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_macc_ctrl.sv
// Directed bench for macc_ctrl with N_ELEM=4, COMPUTE_CYCLES=8.
module tb_macc_ctrl;

    localparam int N  = 4;
    localparam int CC = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] mat_wdata;
    logic [2:0]  wen, ren;
    logic [31:0] c_rdata = '0;
    logic [31:0] perf_cycles;

    int          n_checks = 0;
    int          n_err = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          rd_idx = 0;
    logic [31:0] job_base = '0;

    macc_ctrl #(.N_ELEM(N), .COMPUTE_CYCLES(CC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mat_wdata   (mat_wdata),
        .wen         (wen),
        .ren         (ren),
        .c_rdata     (c_rdata),
        .perf_cycles (perf_cycles)
    );

    always #5 CLK = ~CLK;

    // MACC C-memory model: word k of a job reads back as job_base + k.
    always @(posedge CLK) begin
        if (RST || (start && !busy)) rd_idx <= 0;
        else if (ren[0]) rd_idx <= rd_idx + 1;
        c_rdata <= ren[0] ? job_base + 32'(rd_idx) : 32'hBAD0_0000;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic sample();
        #1;
        if (busy) busy_cnt++;
    endtask

    task automatic start_job(input logic [31:0] base);
        job_base = base;
        tick();
        start = 1'b1;
        busy_cnt = 0;
        sample();
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_in_ready", {31'd0, in_ready}, 0);
        chk("idle_wen", {29'd0, wen}, 0);
    endtask

    task automatic load_phase(input int ph, input bit gaps,
                              input bit poke);
        int  i = 0;
        int  cyc = 0;
        bit  v;
        logic [2:0] we;
        we = (ph == 0) ? 3'b100 : 3'b010;
        while (i < N && cyc < 40) begin
            tick();
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = 32'(ph * N + i + 1);
            start    = poke && (cyc == 1);
            sample();
            chk("load_in_ready", {31'd0, in_ready}, 1);
            chk("load_busy", {31'd0, busy}, 1);
            chk("load_wen", {29'd0, wen}, v ? {29'd0, we} : 0);
            chk("load_wdata", mat_wdata, v ? in_data : 0);
            chk("load_ren", {29'd0, ren}, 0);
            if (v) i++;
            cyc++;
        end
        chk("load_beats", i, N);
    endtask

    task automatic compute_phase();
        for (int k = 0; k < CC; k++) begin
            tick();
            sample();
            chk("cmp_busy", {31'd0, busy}, 1);
            chk("cmp_in_ready", {31'd0, in_ready}, 0);
            chk("cmp_wen", {29'd0, wen}, 0);
            chk("cmp_ren", {29'd0, ren}, 0);
        end
    endtask

    task automatic drain_phase(input int stall_len, input int stop_at);
        int occ = 0;
        int infl = 0;
        int issued = 0;
        int got = 0;
        int cyc = 0;
        int stall_left = 0;
        bit seen = 0;
        bit exp_ren, pop;
        while (got < N && cyc < 100) begin
            tick();
            if (!seen && occ > 0) begin
                seen = 1;
                stall_left = stall_len;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            sample();
            exp_ren = (occ + infl < 2) && (issued < N);
            chk("drn_ren", {29'd0, ren}, {31'd0, exp_ren});
            chk("drn_wen", {29'd0, wen}, 0);
            chk("drn_out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
            if (occ > 0) chk("drn_out_data", out_data, job_base + 32'(got));
            pop = (occ > 0) && out_ready;
            occ = occ + infl - int'(pop);
            infl = int'(exp_ren);
            issued += int'(exp_ren);
            got += int'(pop);
            cyc++;
            if (stop_at > 0 && got == stop_at) break;
        end
        if (stop_at == 0) chk("drn_words", got, N);
        out_ready = 1'b1;
    endtask

    task automatic finish_job(input int done_before);
        tick();
        sample();
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_busy", {31'd0, busy}, 1);
        chk("done_ren", {29'd0, ren}, 0);
        chk("done_out_valid", {31'd0, out_valid}, 0);
        tick();
        sample();
        chk("post_done", {31'd0, done}, 0);
        chk("post_busy", {31'd0, busy}, 0);
        chk("done_count", done_cnt, done_before + 1);
    endtask

    initial begin
        int d0;
        tick();
        tick();
        sample();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wdata", mat_wdata, 0);
        chk("rst_wen", {29'd0, wen}, 0);
        chk("rst_ren", {29'd0, ren}, 0);
        chk("rst_perf", perf_cycles, 0);
        tick();
        RST = 1'b0;
        sample();

        // Job 1: no stalls
        d0 = done_cnt;
        start_job(32'hC0DE_0000);
        load_phase(0, 0, 0);
        load_phase(1, 0, 0);
        compute_phase();
        drain_phase(0, 0);
        finish_job(d0);
        chk("job1_busy_cycles", busy_cnt, 24);
`ifdef MACC_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, busy_cnt);
`else
        chk("perf_cycles", perf_cycles, 0);
`endif

        // Job 2: input gaps
        d0 = done_cnt;
        start_job(32'h0000_A000);
        load_phase(0, 1, 0);
        load_phase(1, 1, 0);
        compute_phase();
        drain_phase(0, 0);
        finish_job(d0);

        // Job 3: start poked while busy, plus output backpressure
        d0 = done_cnt;
        start_job(32'h5500_0010);
        load_phase(0, 0, 0);
        load_phase(1, 0, 1);
        compute_phase();
        drain_phase(5, 0);
        finish_job(d0);
        tick();
        sample();
        chk("poke_ignored", {31'd0, busy}, 0);

        // Job 4: reset in DRAIN after 2 words
        d0 = done_cnt;
        start_job(32'h0BAD_0100);
        load_phase(0, 0, 0);
        load_phase(1, 0, 0);
        compute_phase();
        drain_phase(0, 2);
        tick();
        RST = 1'b1;
        sample();
        tick();
        RST = 1'b0;
        sample();
        chk("rstd_busy", {31'd0, busy}, 0);
        chk("rstd_out_valid", {31'd0, out_valid}, 0);
        chk("rstd_ren", {29'd0, ren}, 0);
        chk("rstd_out_data", out_data, 0);
        chk("rstd_perf", perf_cycles, 0);
        chk("rstd_no_done", done_cnt, d0);

        // Job 5: normal job after the reset
        d0 = done_cnt;
        start_job(32'h7777_0000);
        load_phase(0, 0, 0);
        load_phase(1, 0, 0);
        compute_phase();
        drain_phase(0, 0);
        finish_job(d0);
        chk("job5_busy_cycles", busy_cnt, 24);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
